// File: rtl/sram_port_arbiter_if.sv
// Bundle of the two master ports and the SRAM pin group of sram_port_arbiter.
// The slave modport is the arbiter's view; the master modport is the client/pad view.
interface sram_port_arbiter_if;
  logic        a_req;
  logic        b_req;
  logic        a_wr;
  logic        b_wr;
  logic [18:0] a_addr;
  logic [18:0] b_addr;
  logic [3:0]  a_be;
  logic [3:0]  b_be;
  logic [31:0] a_wdata;
  logic [31:0] b_wdata;
  logic [31:0] a_rdata;
  logic [31:0] b_rdata;
  logic        a_ack;
  logic        b_ack;
  logic        ram_cs_b;
  logic        ram_oe_b;
  logic        ram_we_b;
  logic [3:0]  ram_be_b;
  logic [18:0] ram_addr;
  logic [31:0] ram_dout;
  logic        ram_doe;
  logic [31:0] ram_din;

  modport slave (
    input  a_req, b_req, a_wr, b_wr, a_addr, b_addr, a_be, b_be, a_wdata, b_wdata, ram_din,
    output a_rdata, b_rdata, a_ack, b_ack,
           ram_cs_b, ram_oe_b, ram_we_b, ram_be_b, ram_addr, ram_dout, ram_doe
  );

  modport master (
    output a_req, b_req, a_wr, b_wr, a_addr, b_addr, a_be, b_be, a_wdata, b_wdata, ram_din,
    input  a_rdata, b_rdata, a_ack, b_ack,
           ram_cs_b, ram_oe_b, ram_we_b, ram_be_b, ram_addr, ram_dout, ram_doe
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter/sequencer for a 512K x 32 async SRAM with programmable strobe latencies.
// Define SRAMARB_NATIVE_BE_EN to drive byte-lane enables directly instead of read-modify-write.
module sram_port_arbiter #(
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned WR_LAT     = 1,
  parameter int unsigned RMW_RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  sram_port_arbiter_if.slave  bus
);

  localparam logic [2:0] RD_LAT_C     = 3'(RD_LAT);
  localparam logic [2:0] WR_LAT_C     = 3'(WR_LAT);
  localparam logic [2:0] RMW_RD_LAT_C = 3'(RMW_RD_LAT);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  function automatic logic [31:0] merge_lanes(input logic [31:0] wdata,
                                              input logic [31:0] rdata,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = rdata;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = wdata[8*i +: 8];
      end else begin
        res[8*i +: 8] = rdata[8*i +: 8];
      end
    end
    return res;
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  lcount_q, lcount_d;
  logic        last_q, last_d;   // 1 = port B was granted last
  logic        gnt_q, gnt_d;     // 1 = port B owns the current access
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] a_rdata_q, a_rdata_d;
  logic [31:0] b_rdata_q, b_rdata_d;
  logic        a_ack_q, a_ack_d;
  logic        b_ack_q, b_ack_d;
  logic        cs_b_q, cs_b_d;
  logic        oe_b_q, oe_b_d;
  logic        we_b_q, we_b_d;
  logic [3:0]  be_b_q, be_b_d;
  logic [18:0] addr_q, addr_d;
  logic [31:0] dout_q, dout_d;
  logic        doe_q, doe_d;

  logic        sel_s;
  logic        req_wr_s;
  logic [18:0] req_addr_s;
  logic [3:0]  req_be_s;
  logic [31:0] req_wdata_s;

  assign sel_s       = (bus.a_req && bus.b_req) ? ~last_q : bus.b_req;
  assign req_wr_s    = sel_s ? bus.b_wr    : bus.a_wr;
  assign req_addr_s  = sel_s ? bus.b_addr  : bus.a_addr;
  assign req_be_s    = sel_s ? bus.b_be    : bus.a_be;
  assign req_wdata_s = sel_s ? bus.b_wdata : bus.a_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      lcount_q  <= 3'd0;
      last_q    <= 1'b1;
      gnt_q     <= 1'b0;
      be_q      <= 4'd0;
      wdata_q   <= 32'd0;
      a_rdata_q <= 32'd0;
      b_rdata_q <= 32'd0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      cs_b_q    <= 1'b1;
      oe_b_q    <= 1'b1;
      we_b_q    <= 1'b1;
      be_b_q    <= 4'b1111;
      addr_q    <= 19'd0;
      dout_q    <= 32'd0;
      doe_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lcount_q  <= lcount_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      cs_b_q    <= cs_b_d;
      oe_b_q    <= oe_b_d;
      we_b_q    <= we_b_d;
      be_b_q    <= be_b_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      doe_q     <= doe_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lcount_d  = lcount_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    cs_b_d    = cs_b_q;
    oe_b_d    = oe_b_q;
    we_b_d    = we_b_q;
    be_b_d    = be_b_q;
    addr_d    = addr_q;
    dout_d    = dout_q;
    doe_d     = doe_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.a_req || bus.b_req) begin
          gnt_d   = sel_s;
          last_d  = sel_s;
          be_d    = req_be_s;
          wdata_d = req_wdata_s;
          addr_d  = req_addr_s;
          cs_b_d  = 1'b0;
          be_b_d  = 4'b0000;
          if (!req_wr_s) begin
            oe_b_d   = 1'b0;
            lcount_d = RD_LAT_C;
            state_d  = ST_READ;
          end else if (req_be_s == 4'b1111) begin
            we_b_d   = 1'b0;
            doe_d    = 1'b1;
            dout_d   = req_wdata_s;
            lcount_d = WR_LAT_C;
            state_d  = ST_WRITE;
          end else begin
`ifdef SRAMARB_NATIVE_BE_EN
            we_b_d   = 1'b0;
            doe_d    = 1'b1;
            dout_d   = req_wdata_s;
            be_b_d   = ~req_be_s;
            lcount_d = WR_LAT_C;
            state_d  = ST_WRITE;
`else
            oe_b_d   = 1'b0;
            lcount_d = RMW_RD_LAT_C;
            state_d  = ST_RMW_RD;
`endif
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_READ: begin
        if (lcount_q != 3'd0) begin
          lcount_d = lcount_q - 3'd1;
        end else begin
          if (gnt_q) begin
            b_rdata_d = bus.ram_din;
            b_ack_d   = 1'b1;
          end else begin
            a_rdata_d = bus.ram_din;
            a_ack_d   = 1'b1;
          end
          cs_b_d  = 1'b1;
          oe_b_d  = 1'b1;
          be_b_d  = 4'b1111;
          state_d = ST_DONE;
        end
      end

      // Old word is sampled on the last read cycle and merged into the write data.
      ST_RMW_RD: begin
        if (lcount_q != 3'd0) begin
          lcount_d = lcount_q - 3'd1;
        end else begin
          oe_b_d   = 1'b1;
          we_b_d   = 1'b0;
          doe_d    = 1'b1;
          dout_d   = merge_lanes(wdata_q, bus.ram_din, be_q);
          lcount_d = WR_LAT_C;
          state_d  = ST_WRITE;
        end
      end

      ST_WRITE: begin
        if (lcount_q != 3'd0) begin
          lcount_d = lcount_q - 3'd1;
        end else begin
          if (gnt_q) begin
            b_ack_d = 1'b1;
          end else begin
            a_ack_d = 1'b1;
          end
          cs_b_d  = 1'b1;
          oe_b_d  = 1'b1;
          we_b_d  = 1'b1;
          be_b_d  = 4'b1111;
          doe_d   = 1'b0;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cs_b_d  = 1'b1;
        oe_b_d  = 1'b1;
        we_b_d  = 1'b1;
        be_b_d  = 4'b1111;
        doe_d   = 1'b0;
      end
    endcase
  end

  assign bus.a_rdata  = a_rdata_q;
  assign bus.b_rdata  = b_rdata_q;
  assign bus.a_ack    = a_ack_q;
  assign bus.b_ack    = b_ack_q;
  assign bus.ram_cs_b = cs_b_q;
  assign bus.ram_oe_b = oe_b_q;
  assign bus.ram_we_b = we_b_q;
  assign bus.ram_be_b = be_b_q;
  assign bus.ram_addr = addr_q;
  assign bus.ram_dout = dout_q;
  assign bus.ram_doe  = doe_q;

endmodule
